// File: rtl/sha_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// sha_mem_arbiter_if
//
// Bundles everything that passes between the SHA-256 engines, the shared
// message/output memory and the arbiter that sits between them.
//
// Engine side (NUM_REQ lanes, one per engine):
//   req        engine -> arb  per-engine access request (level)
//   req_we     engine -> arb  write enable, meaningful while req is high
//   req_last   engine -> arb  final beat of the current burst
//   req_addr   engine -> arb  16-bit word address
//   req_wdata  engine -> arb  32-bit write data
//   gnt        arb -> engine  one-hot grant, registered
//   rd_valid   arb -> engine  one-hot, rd_data valid for that engine's read
//   rd_data    arb -> engine  memory read data, broadcast
//   busy       arb -> env     arbiter is in BURST or RELEASE
// Memory side:
//   mem_we, mem_addr, mem_write_data   arb -> memory
//   mem_read_data                      memory -> arb (one cycle after address)
//
// Modports:
//   slave   the arbiter's view
//   master  the environment's view (engines plus memory)
// -----------------------------------------------------------------------------
interface sha_mem_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0][15:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       rd_valid;
  logic [31:0]              rd_data;
  logic                     busy;

  logic                     mem_we;
  logic [15:0]              mem_addr;
  logic [31:0]              mem_write_data;
  logic [31:0]              mem_read_data;

  modport slave (
    input  req, req_we, req_last, req_addr, req_wdata, mem_read_data,
    output gnt, rd_valid, rd_data, busy, mem_we, mem_addr, mem_write_data
  );

  modport master (
    output req, req_we, req_last, req_addr, req_wdata, mem_read_data,
    input  gnt, rd_valid, rd_data, busy, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/sha_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sha_mem_arbiter
//
// Round-robin arbiter sharing one message/output memory port among NUM_REQ
// SHA-256 engines. One engine owns the bus at a time for a burst of up to
// MAX_BURST beats; its address, write data and write enable are muxed onto
// the memory bus and read-data-valid is steered back to it one cycle later.
// Every burst is followed by exactly one RELEASE cycle with the bus idle,
// during which the next owner is chosen starting from the engine after the
// previous owner.
//
// Parameters:
//   NUM_REQ    number of requesting engines (2..8)
//   MAX_BURST  beats per grant before forced rotation (1..64)
//
// Ports:
//   clk       in   clock, also forwarded to mem_clk
//   reset_n   in   synchronous active-low reset
//   mem_clk   out  memory clock, identical to clk
//   bus       slave modport of sha_mem_arbiter_if (engine and memory signals)
// -----------------------------------------------------------------------------
module sha_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_clk,
  sha_mem_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_RELEASE
  } state_e;

  // Result of one round-robin search.
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e             state_q,    state_d;
  logic [NUM_REQ-1:0] gnt_q,      gnt_d;
  logic [IDX_W-1:0]   owner_q,    owner_d;
  logic [IDX_W-1:0]   ptr_q,      ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
  logic               busy_q,     busy_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // First requester found scanning start, start+1, ... modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] r,
                                    input logic [IDX_W-1:0]   start);
    pick_t p;
    int    cand;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(start) + i) % NUM_REQ;
      if (!p.found && r[cand]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(cand);
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Owner-side view of the request lanes
  // ---------------------------------------------------------------------------
  logic        own_req;
  logic        own_we;
  logic        own_last;
  logic [15:0] own_addr;
  logic [31:0] own_wdata;
  pick_t       pick;

  assign own_req   = bus.req[owner_q];
  assign own_we    = bus.req_we[owner_q];
  assign own_last  = bus.req_last[owner_q];
  assign own_addr  = bus.req_addr[owner_q];
  assign own_wdata = bus.req_wdata[owner_q];

  // ptr_q already points past the previous owner by the time RELEASE runs
  // its search, so rotation falls out of the pointer update at burst end.
  assign pick = rr_pick(bus.req, ptr_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic burst_end;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    rd_valid_d = '0;
    burst_end  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        if (pick.found) begin
          state_d    = ST_BURST;
          owner_d    = pick.idx;
          gnt_d      = onehot(pick.idx);
          beat_cnt_d = '0;
        end
      end

      ST_BURST: begin
        if (own_req) begin
          // A beat: the access happens this cycle.
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (!own_we) begin
            rd_valid_d = onehot(owner_q);
          end
          // req_last and the beat limit landing together is one end.
          if (own_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
            burst_end = 1'b1;
          end
        end else begin
          // Owner dropped its request mid-burst: abort, no access.
          burst_end = 1'b1;
        end

        if (burst_end) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; asserting it mid-burst
    // drops the grant at the next edge and discards any in-flight read valid.
    if (!reset_n) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, independent of statement order.
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
      rd_valid_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory bus mux: driven from the owner only while in BURST, otherwise idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    if (state_q == ST_BURST) begin
      bus.mem_addr       = own_addr;
      bus.mem_write_data = own_wdata;
      bus.mem_we         = own_we & own_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_clk      = clk;
  assign bus.gnt      = gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bus.mem_read_data;
  assign bus.busy     = busy_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt_q));

  a_rd_valid_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(rd_valid_q));

  a_gnt_only_in_burst : assert property (@(posedge clk) disable iff (!reset_n)
    ((gnt_q != '0) == (state_q == ST_BURST)));

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sha_mem_arbiter
//
// Directed bench for sha_mem_arbiter. Stimulus tasks play the engines and
// push the expected grants, reads and writes into queues; a monitor process
// on the falling edge pops and compares whenever the DUT presents a grant,
// a read-valid or a memory write. The memory model returns {16'hD00D, addr}
// for never-written words, so read data expectations are fixed constants.
// -----------------------------------------------------------------------------
module tb_sha_mem_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 16;

  typedef struct {
    int          eng;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    int eng;
    int dur;   // cycles gnt stays high
    int gap;   // idle cycles before this grant, -1 = don't care
  } gnt_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_clk;

  int n_vec  = 0;
  int n_fail = 0;

  rd_exp_t  rd_q[$];
  gnt_exp_t gnt_q[$];
  wr_exp_t  wr_q[$];

  sha_mem_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  sha_mem_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .mem_clk(mem_clk),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory model: one-cycle read latency, clocked by the forwarded mem_clk.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [65536];
  bit          written [65536];

  always @(posedge mem_clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_write_data;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_read_data <= written[bus.mem_addr] ? mem[bus.mem_addr]
                                               : {16'hD00D, bus.mem_addr};
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int e);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[e] = 1'b1;
    return v;
  endfunction

  function automatic rd_exp_t mk_rd(input int e, input logic [31:0] d);
    rd_exp_t r;
    r.eng  = e;
    r.data = d;
    return r;
  endfunction

  function automatic gnt_exp_t mk_gnt(input int e, input int dur, input int gap);
    gnt_exp_t g;
    g.eng = e;
    g.dur = dur;
    g.gap = gap;
    return g;
  endfunction

  function automatic wr_exp_t mk_wr(input logic [15:0] a, input logic [31:0] d);
    wr_exp_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // One engine burst: requests, advances address/data on every beat it owns,
  // raises req_last on the final beat if use_last, then drops req. Without
  // req_last the drop after the final beat makes the next owned cycle an abort.
  task automatic run_burst(input int e, input bit we, input logic [15:0] base,
                           input int nbeats, input bit use_last,
                           input logic [31:0] dbase);
    int   done;
    int   waited;
    logic g;
    done   = 0;
    waited = 0;
    bus.req_we[e]    = we;
    bus.req_addr[e]  = base;
    bus.req_wdata[e] = dbase;
    bus.req_last[e]  = use_last && (nbeats == 1);
    bus.req[e]       = 1'b1;
    while (done < nbeats) begin
      @(negedge clk);
      g = bus.gnt[e];
      @(posedge clk);
      #1;
      if (g) begin
        done++;
        bus.req_addr[e]  = base + 16'(done);
        bus.req_wdata[e] = dbase + 32'(done);
        bus.req_last[e]  = use_last && (done == nbeats - 1);
      end else begin
        waited++;
        if (waited > 400) begin
          check("grant_timeout", 64'(e), 64'hFF);
          break;
        end
      end
    end
    bus.req[e]      = 1'b0;
    bus.req_last[e] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] exp_rv    = '0;
  logic [NUM_REQ-1:0] prev_gnt  = '0;
  logic               prev_rstn = 1'b0;
  int                 gnt_dur   = 0;
  int                 gap_cnt   = 0;
  int                 cur_dur   = 0;
  rd_exp_t            mon_r;
  gnt_exp_t           mon_g;
  wr_exp_t            mon_w;

  always @(negedge clk) begin
    // Read-valid must follow a read beat by exactly one cycle.
    check("rd_valid_timing", 64'(bus.rd_valid), 64'(exp_rv));
    if (bus.rd_valid != '0) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 64'(bus.rd_valid), 64'h0);
      end else begin
        mon_r = rd_q.pop_front();
        check("rd_owner", 64'(bus.rd_valid), 64'(oh(mon_r.eng)));
        check("rd_data", 64'(bus.rd_data), 64'(mon_r.data));
      end
    end
    for (int e = 0; e < NUM_REQ; e++) begin
      exp_rv[e] = reset_n && bus.gnt[e] && bus.req[e] && !bus.req_we[e];
    end

    // Grant sequence, hold time and RELEASE spacing.
    check("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'h1);
    if (bus.gnt != '0 && prev_gnt == '0) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 64'(bus.gnt), 64'h0);
        cur_dur = -1;
      end else begin
        mon_g = gnt_q.pop_front();
        check("gnt_owner", 64'(bus.gnt), 64'(oh(mon_g.eng)));
        if (mon_g.gap >= 0) check("gnt_gap", 64'(gap_cnt), 64'(mon_g.gap));
        cur_dur = mon_g.dur;
      end
      gnt_dur = 1;
    end else if (bus.gnt != '0) begin
      check("gnt_hold", 64'(bus.gnt), 64'(prev_gnt));
      gnt_dur++;
    end else if (prev_gnt != '0) begin
      if (cur_dur >= 0) check("gnt_dur", 64'(gnt_dur), 64'(cur_dur));
      gap_cnt = 1;
    end else begin
      gap_cnt++;
    end

    // Bus is idle whenever nobody holds the grant.
    if (bus.gnt == '0) begin
      check("idle_bus", {15'h0, bus.mem_we, bus.mem_addr, bus.mem_write_data}, 64'h0);
    end

    // Memory writes in order.
    if (bus.mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", {bus.mem_addr, bus.mem_write_data}, 64'h0);
      end else begin
        mon_w = wr_q.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(mon_w.addr));
        check("wr_data", 64'(bus.mem_write_data), 64'(mon_w.data));
      end
    end

    // busy: high during a burst and during the RELEASE cycle after it.
    if (reset_n && prev_rstn) begin
      check("busy", 64'(bus.busy), 64'((bus.gnt != '0) || (prev_gnt != '0)));
    end

    prev_gnt  = bus.gnt;
    prev_rstn = reset_n;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;

    reset_n       = 1'b0;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_last  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(bus.gnt), 64'h0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_mem_we", 64'(bus.mem_we), 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_cycles(2);

    // Single read burst: engine 0, 3 beats at 0x0010..0x0012.
    gnt_q.push_back(mk_gnt(0, 3, -1));
    rd_q.push_back(mk_rd(0, 32'hD00D_0010));
    rd_q.push_back(mk_rd(0, 32'hD00D_0011));
    rd_q.push_back(mk_rd(0, 32'hD00D_0012));
    run_burst(0, 1'b0, 16'h0010, 3, 1'b1, 32'h0);
    idle_cycles(3);
    @(negedge clk);
    check("t1_busy_idle", 64'(bus.busy), 64'h0);
    check("t1_gnt_idle", 64'(bus.gnt), 64'h0);
    idle_cycles(1);

    // Write path: engine 3 writes 8 words 0xA0000000+i to 0x0100+i.
    gnt_q.push_back(mk_gnt(3, 8, -1));
    for (int i = 0; i < 8; i++) wr_q.push_back(mk_wr(16'h0100 + 16'(i), 32'hA000_0000 + 32'(i)));
    run_burst(3, 1'b1, 16'h0100, 8, 1'b1, 32'hA000_0000);
    idle_cycles(3);
    for (int i = 0; i < 8; i++) check("t2_mem", 64'(mem[16'h0100 + 16'(i)]), 64'(32'hA000_0000 + 32'(i)));

    // Contention: all four request 2-beat reads; owners 0,1,2,3,0.
    gnt_q.push_back(mk_gnt(0, 2, -1));
    gnt_q.push_back(mk_gnt(1, 2, 1));
    gnt_q.push_back(mk_gnt(2, 2, 1));
    gnt_q.push_back(mk_gnt(3, 2, 1));
    gnt_q.push_back(mk_gnt(0, 2, 1));
    rd_q.push_back(mk_rd(0, 32'hD00D_0040)); rd_q.push_back(mk_rd(0, 32'hD00D_0041));
    rd_q.push_back(mk_rd(1, 32'hD00D_0050)); rd_q.push_back(mk_rd(1, 32'hD00D_0051));
    rd_q.push_back(mk_rd(2, 32'hD00D_0060)); rd_q.push_back(mk_rd(2, 32'hD00D_0061));
    rd_q.push_back(mk_rd(3, 32'hD00D_0070)); rd_q.push_back(mk_rd(3, 32'hD00D_0071));
    rd_q.push_back(mk_rd(0, 32'hD00D_0048)); rd_q.push_back(mk_rd(0, 32'hD00D_0049));
    fork
      begin
        run_burst(0, 1'b0, 16'h0040, 2, 1'b1, 32'h0);
        run_burst(0, 1'b0, 16'h0048, 2, 1'b1, 32'h0);
      end
      run_burst(1, 1'b0, 16'h0050, 2, 1'b1, 32'h0);
      run_burst(2, 1'b0, 16'h0060, 2, 1'b1, 32'h0);
      run_burst(3, 1'b0, 16'h0070, 2, 1'b1, 32'h0);
    join
    idle_cycles(3);

    // req_last on the MAX_BURST-th beat: one 16-cycle grant.
    gnt_q.push_back(mk_gnt(0, 16, -1));
    for (int i = 0; i < 16; i++) wr_q.push_back(mk_wr(16'h0180 + 16'(i), 32'hB000_0000 + 32'(i)));
    run_burst(0, 1'b1, 16'h0180, 16, 1'b1, 32'hB000_0000);
    idle_cycles(3);

    // Abort: engine 2 drops req after one write beat; 3 must follow before 0.
    gnt_q.push_back(mk_gnt(2, 2, -1));
    gnt_q.push_back(mk_gnt(3, 1, 1));
    gnt_q.push_back(mk_gnt(0, 1, 1));
    wr_q.push_back(mk_wr(16'h01F0, 32'hCAFE_0000));
    rd_q.push_back(mk_rd(3, 32'hD00D_0030));
    rd_q.push_back(mk_rd(0, 32'hD00D_0031));
    fork
      run_burst(2, 1'b1, 16'h01F0, 1, 1'b0, 32'hCAFE_0000);
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = bus.gnt[2];
        end
        check("t5_gnt2_seen", 64'(seen), 64'h1);
        fork
          run_burst(3, 1'b0, 16'h0030, 1, 1'b1, 32'h0);
          run_burst(0, 1'b0, 16'h0031, 1, 1'b1, 32'h0);
        join
      end
    join
    idle_cycles(3);

    // Forced rotation: engine 1 holds 20 read beats without req_last while
    // engine 2 waits with a 2-beat write.
    gnt_q.push_back(mk_gnt(1, 16, -1));
    gnt_q.push_back(mk_gnt(2, 2, 1));
    gnt_q.push_back(mk_gnt(1, 5, 1));
    for (int i = 0; i < 20; i++) rd_q.push_back(mk_rd(1, 32'hD00D_0200 + 32'(i)));
    wr_q.push_back(mk_wr(16'h0220, 32'hE000_0000));
    wr_q.push_back(mk_wr(16'h0221, 32'hE000_0001));
    fork
      run_burst(1, 1'b0, 16'h0200, 20, 1'b0, 32'h0);
      run_burst(2, 1'b1, 16'h0220, 2, 1'b1, 32'hE000_0000);
    join
    idle_cycles(3);

    // Reset mid-burst: engine 2 reads 0x0300, reset during beat 2.
    gnt_q.push_back(mk_gnt(2, 2, -1));
    rd_q.push_back(mk_rd(2, 32'hD00D_0300));
    bus.req_we[2]   = 1'b0;
    bus.req_addr[2] = 16'h0300;
    bus.req_last[2] = 1'b0;
    bus.req[2]      = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.gnt[2];
    end
    check("t7_gnt2_seen", 64'(seen), 64'h1);
    @(posedge clk);
    #1;
    bus.req_addr[2] = 16'h0301;
    reset_n         = 1'b0;
    @(posedge clk);
    #1;
    bus.req[2] = 1'b0;
    @(negedge clk);
    check("t7_rst_gnt", 64'(bus.gnt), 64'h0);
    check("t7_rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    check("t7_rst_busy", 64'(bus.busy), 64'h0);
    check("t7_rst_bus", {15'h0, bus.mem_we, bus.mem_addr, bus.mem_write_data}, 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle_cycles(1);

    // After reset the search starts from 0, so engine 1 wins over engine 3.
    gnt_q.push_back(mk_gnt(1, 2, -1));
    gnt_q.push_back(mk_gnt(3, 2, 1));
    rd_q.push_back(mk_rd(1, 32'hD00D_0350)); rd_q.push_back(mk_rd(1, 32'hD00D_0351));
    rd_q.push_back(mk_rd(3, 32'hD00D_0370)); rd_q.push_back(mk_rd(3, 32'hD00D_0371));
    fork
      run_burst(1, 1'b0, 16'h0350, 2, 1'b1, 32'h0);
      run_burst(3, 1'b0, 16'h0370, 2, 1'b1, 32'h0);
    join
    idle_cycles(4);

    // Everything promised was delivered.
    check("rd_q_drained", 64'(rd_q.size()), 64'h0);
    check("gnt_q_drained", 64'(gnt_q.size()), 64'h0);
    check("wr_q_drained", 64'(wr_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
